risc_datapath: RTL and testbench

Bus-organised 32-bit execution datapath for the ezRISC processor. It holds the register file, special registers (PC, IR, HI, LO, Y, Z, MAR, MDR) and the ALU, all joined by one shared 32-bit bus. An external control unit (or testbench FSM) drives it with per-register in/out strobes and an ALU opcode. Every transfer is "one source drives the bus; selected destinations latch on the next rising clock edge".

---
 rtl/risc_pkg.sv | 21 ++
 rtl/risc_alu.sv | 49 ++++
 rtl/risc_datapath.sv | 115 +++++++++++
 tb/tb_risc_datapath.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/risc_pkg.sv
// Shared definitions for the ezRISC datapath: data width, register count and
// ALU opcode encodings.
package risc_pkg;
    localparam int DATA_W  = 32;
    localparam int NUM_GPR = 16;

    typedef enum logic [3:0] {
        ALU_AND = 4'd0,
        ALU_OR  = 4'd1,
        ALU_ADD = 4'd2,
        ALU_SUB = 4'd3,
        ALU_SHR = 4'd4,
        ALU_SHL = 4'd5,
        ALU_ROR = 4'd6,
        ALU_ROL = 4'd7,
        ALU_MUL = 4'd8,
        ALU_DIV = 4'd9,
        ALU_NEG = 4'd10,
        ALU_NOT = 4'd11
    } alu_op_e;
endpackage

// File: rtl/risc_alu.sv
// Combinational ALU: A (from Y) and B (from the bus) produce a 64-bit result
// that is latched into Z by the datapath.
module risc_alu
    import risc_pkg::*;
(
    input  logic [DATA_W-1:0]   a_i,
    input  logic [DATA_W-1:0]   b_i,
    input  logic [3:0]          alu_op_i,
    input  logic                inc_pc_i,
    output logic [2*DATA_W-1:0] result_o
);
    logic [2*DATA_W-1:0]        rot_r, rot_l;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [DATA_W-1:0]   quot, rem;

    // Rotates fall out of shifting a doubled copy of A
    assign rot_r = {a_i, a_i} >> b_i[4:0];
    assign rot_l = {a_i, a_i} << b_i[4:0];
    assign prod  = $signed({{DATA_W{a_i[DATA_W-1]}}, a_i}) *
                   $signed({{DATA_W{b_i[DATA_W-1]}}, b_i});
    assign quot  = $signed(a_i) / $signed(b_i);
    assign rem   = $signed(a_i) % $signed(b_i);

    always_comb begin
        result_o = '0;
        if (inc_pc_i) begin
            result_o[DATA_W-1:0] = b_i + 32'd1;
        end else begin
            case (alu_op_e'(alu_op_i))
                ALU_AND: result_o[DATA_W-1:0] = a_i & b_i;
                ALU_OR:  result_o[DATA_W-1:0] = a_i | b_i;
                ALU_ADD: result_o[DATA_W-1:0] = a_i + b_i;
                ALU_SUB: result_o[DATA_W-1:0] = a_i - b_i;
                ALU_SHR: result_o[DATA_W-1:0] = a_i >> b_i[4:0];
                ALU_SHL: result_o[DATA_W-1:0] = a_i << b_i[4:0];
                ALU_ROR: result_o[DATA_W-1:0] = rot_r[DATA_W-1:0];
                ALU_ROL: result_o[DATA_W-1:0] = rot_l[2*DATA_W-1:DATA_W];
                ALU_MUL: result_o = prod;
                ALU_DIV: begin
                    if (b_i == '0) result_o = {a_i, {DATA_W{1'b1}}};
                    else           result_o = {rem, quot};
                end
                ALU_NEG: result_o[DATA_W-1:0] = -b_i;
                ALU_NOT: result_o[DATA_W-1:0] = ~b_i;
                default: result_o = '0;
            endcase
        end
    end
endmodule

// File: rtl/risc_datapath.sv
// Bus-organised ezRISC datapath: GPRs, special registers, bus mux and ALU.
// Define RISC_DATAPATH_INPORT_EN to add the sampled input port (inport_data).
module risc_datapath
    import risc_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_GPR-1:0]  gpr_in,
    input  logic [NUM_GPR-1:0]  gpr_out,
    input  logic                hi_in,
    input  logic                lo_in,
    input  logic                hi_out,
    input  logic                lo_out,
    input  logic                pc_in,
    input  logic                pc_out,
    input  logic                ir_in,
    input  logic                y_in,
    input  logic                z_in,
    input  logic                z_high_out,
    input  logic                z_low_out,
    input  logic                inport_out,
    input  logic                c_out,
    input  logic                mar_in,
    input  logic                mdr_in,
    input  logic                mdr_out,
    input  logic                read,
    input  logic [DATA_W-1:0]   m_data_in,
`ifdef RISC_DATAPATH_INPORT_EN
    input  logic [DATA_W-1:0]   inport_data,
`endif
    input  logic [3:0]          alu_op,
    input  logic                inc_pc,
    output logic [DATA_W-1:0]   bus_data
);
    logic [DATA_W-1:0]   gpr_q [NUM_GPR];
    logic [DATA_W-1:0]   gpr_d [NUM_GPR];
    logic [DATA_W-1:0]   hi_q, lo_q, pc_q, ir_q, y_q, mar_q, mdr_q;
    logic [DATA_W-1:0]   hi_d, lo_d, pc_d, ir_d, y_d, mar_d, mdr_d;
    logic [2*DATA_W-1:0] z_q, z_d, alu_res;
    logic [DATA_W-1:0]   inport_val, bus;

`ifdef RISC_DATAPATH_INPORT_EN
    logic [DATA_W-1:0] inport_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) inport_q <= '0;
        else       inport_q <= inport_data;
    end
    assign inport_val = inport_q;
`else
    assign inport_val = '0;
`endif

    // Fixed priority; among GPRs the lowest index wins, so scan downward
    always_comb begin
        bus = '0;
        if      (mdr_out)    bus = mdr_q;
        else if (pc_out)     bus = pc_q;
        else if (z_low_out)  bus = z_q[DATA_W-1:0];
        else if (z_high_out) bus = z_q[2*DATA_W-1:DATA_W];
        else if (hi_out)     bus = hi_q;
        else if (lo_out)     bus = lo_q;
        else if (inport_out) bus = inport_val;
        else if (c_out)      bus = {{(DATA_W-19){ir_q[18]}}, ir_q[18:0]};
        else begin
            for (int i = NUM_GPR-1; i >= 0; i--)
                if (gpr_out[i]) bus = gpr_q[i];
        end
    end
    assign bus_data = bus;

    risc_alu u_alu (
        .a_i      (y_q),
        .b_i      (bus),
        .alu_op_i (alu_op),
        .inc_pc_i (inc_pc),
        .result_o (alu_res)
    );

    always_comb begin
        for (int i = 0; i < NUM_GPR; i++)
            gpr_d[i] = gpr_in[i] ? bus : gpr_q[i];
        hi_d  = hi_in  ? bus : hi_q;
        lo_d  = lo_in  ? bus : lo_q;
        pc_d  = pc_in  ? bus : pc_q;
        ir_d  = ir_in  ? bus : ir_q;
        y_d   = y_in   ? bus : y_q;
        mar_d = mar_in ? bus : mar_q;
        mdr_d = mdr_in ? (read ? m_data_in : bus) : mdr_q;
        z_d   = z_in   ? alu_res : z_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_GPR; i++) gpr_q[i] <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            pc_q  <= '0;
            ir_q  <= '0;
            y_q   <= '0;
            mar_q <= '0;
            mdr_q <= '0;
            z_q   <= '0;
        end else begin
            for (int i = 0; i < NUM_GPR; i++) gpr_q[i] <= gpr_d[i];
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            pc_q  <= pc_d;
            ir_q  <= ir_d;
            y_q   <= y_d;
            mar_q <= mar_d;
            mdr_q <= mdr_d;
            z_q   <= z_d;
        end
    end
endmodule

// File: tb/tb_risc_datapath.sv
// Directed bench for risc_datapath: table-driven ALU vectors plus hand-written
// bus/register transfer sequences.
`timescale 1ns/1ps
module tb_risc_datapath;
    import risc_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] gpr_in, gpr_out;
    logic        hi_in, lo_in, hi_out, lo_out, pc_in, pc_out, ir_in, y_in, z_in;
    logic        z_high_out, z_low_out, inport_out, c_out, mar_in, mdr_in, mdr_out, read;
    logic [31:0] m_data_in;
    logic [31:0] inport_data;
    logic [3:0]  alu_op;
    logic        inc_pc;
    logic [31:0] bus_data;

    int total  = 0;
    int passed = 0;

    risc_datapath dut (
        .clk(clk), .reset(reset), .gpr_in(gpr_in), .gpr_out(gpr_out),
        .hi_in(hi_in), .lo_in(lo_in), .hi_out(hi_out), .lo_out(lo_out),
        .pc_in(pc_in), .pc_out(pc_out), .ir_in(ir_in), .y_in(y_in), .z_in(z_in),
        .z_high_out(z_high_out), .z_low_out(z_low_out), .inport_out(inport_out),
        .c_out(c_out), .mar_in(mar_in), .mdr_in(mdr_in), .mdr_out(mdr_out),
        .read(read), .m_data_in(m_data_in),
`ifdef RISC_DATAPATH_INPORT_EN
        .inport_data(inport_data),
`endif
        .alu_op(alu_op), .inc_pc(inc_pc), .bus_data(bus_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic        inc;
        logic [31:0] a, b, lo, hi;
    } vec_t;
    vec_t vecs[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    task automatic clr();
        gpr_in = '0; gpr_out = '0;
        hi_in = 0; lo_in = 0; hi_out = 0; lo_out = 0; pc_in = 0; pc_out = 0;
        ir_in = 0; y_in = 0; z_in = 0; z_high_out = 0; z_low_out = 0;
        inport_out = 0; c_out = 0; mar_in = 0; mdr_in = 0; mdr_out = 0;
        read = 0; alu_op = 4'd0; inc_pc = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put_mdr(input logic [31:0] v);
        clr(); read = 1; m_data_in = v; mdr_in = 1; tick(); clr();
    endtask

    task automatic alu_run(input vec_t v);
        put_mdr(v.a);
        mdr_out = 1; y_in = 1; tick(); clr();
        put_mdr(v.b);
        mdr_out = 1; alu_op = v.op; inc_pc = v.inc; z_in = 1; tick(); clr();
        z_low_out = 1;  #1 chk({v.name, " lo"}, bus_data, v.lo); clr();
        z_high_out = 1; #1 chk({v.name, " hi"}, bus_data, v.hi); clr();
    endtask

    initial begin
        vecs[0]  = '{"and",    4'd0,  0, 32'hF0F01234, 32'h0FF0FFFF, 32'h00F01234, 32'h0};
        vecs[1]  = '{"or",     4'd1,  0, 32'hF0000000, 32'h0000000F, 32'hF000000F, 32'h0};
        vecs[2]  = '{"add",    4'd2,  0, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'h0};
        vecs[3]  = '{"sub",    4'd3,  0, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 32'h0};
        vecs[4]  = '{"shr",    4'd4,  0, 32'h80000000, 32'h00000004, 32'h08000000, 32'h0};
        vecs[5]  = '{"shl",    4'd5,  0, 32'h00000003, 32'h00000021, 32'h00000006, 32'h0};
        vecs[6]  = '{"ror",    4'd6,  0, 32'h80000001, 32'h00000001, 32'hC0000000, 32'h0};
        vecs[7]  = '{"rol",    4'd7,  0, 32'h80000001, 32'h00000004, 32'h00000018, 32'h0};
        vecs[8]  = '{"mul",    4'd8,  0, 32'h00FFFF22, 32'h00FFFF24, 32'h4600BEC8, 32'h0000FFFE};
        vecs[9]  = '{"mulneg", 4'd8,  0, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFF1, 32'hFFFFFFFF};
        vecs[10] = '{"div",    4'd9,  0, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001};
        vecs[11] = '{"divneg", 4'd9,  0, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 32'hFFFFFFFF};
        vecs[12] = '{"div0",   4'd9,  0, 32'h12345678, 32'h00000000, 32'hFFFFFFFF, 32'h12345678};
        vecs[13] = '{"neg",    4'd10, 0, 32'h00000055, 32'h00000001, 32'hFFFFFFFF, 32'h0};
        vecs[14] = '{"not",    4'd11, 0, 32'h00000055, 32'h0F0F0F0F, 32'hF0F0F0F0, 32'h0};
        vecs[15] = '{"op12",   4'd12, 0, 32'h00000001, 32'h00000001, 32'h00000000, 32'h0};
        vecs[16] = '{"incpc",  4'd3,  1, 32'h00000009, 32'h00000041, 32'h00000042, 32'h0};

        clr();
        m_data_in = '0; inport_data = '0;
        reset = 1;
        #12;
        pc_out = 1;     #1 chk("rst pc", bus_data, 32'h0); clr();
        gpr_out = '1;   #1 chk("rst gpr", bus_data, 32'h0); clr();
        z_high_out = 1; #1 chk("rst zhi", bus_data, 32'h0); clr();
        reset = 0;
        tick();

        // Register load into R2 through MDR
        put_mdr(32'h00FFFF22);
        mdr_out = 1; #1 chk("mdr load", bus_data, 32'h00FFFF22);
        gpr_in[2] = 1; tick(); clr();
        gpr_out[2] = 1; #1 chk("r2 load", bus_data, 32'h00FFFF22); clr();

        // PC increment, twice
        for (int k = 0; k < 2; k++) begin
            pc_out = 1; mar_in = 1; inc_pc = 1; z_in = 1; alu_op = 4'd2; tick(); clr();
            z_low_out = 1; pc_in = 1; tick(); clr();
            pc_out = 1; #1 chk("pc inc", bus_data, 32'(k + 1)); clr();
            chk("mar", dut.mar_q, 32'(k));
        end

        // Fetch into IR, then constant sign extension
        put_mdr(32'h71200000);
        mdr_out = 1; ir_in = 1; tick(); clr();
        chk("ir fetch", dut.ir_q, 32'h71200000);
        c_out = 1; #1 chk("c_out pos", bus_data, 32'h0); clr();
        put_mdr(32'h00040005);
        mdr_out = 1; ir_in = 1; tick(); clr();
        c_out = 1; #1 chk("c_out sext", bus_data, 32'hFFFC0005); clr();

        // Multiply R2 * R4, fan the result out to LO, R5 and HI
        put_mdr(32'h00FFFF24);
        mdr_out = 1; gpr_in[4] = 1; tick(); clr();
        gpr_out[2] = 1; y_in = 1; tick(); clr();
        gpr_out[4] = 1; alu_op = 4'd8; z_in = 1; tick(); clr();
        z_low_out = 1; lo_in = 1; gpr_in[5] = 1; tick(); clr();
        z_high_out = 1; hi_in = 1; tick(); clr();
        lo_out = 1;     #1 chk("mul lo", bus_data, 32'h4600BEC8); clr();
        hi_out = 1;     #1 chk("mul hi", bus_data, 32'h0000FFFE); clr();
        gpr_out[5] = 1; #1 chk("mul r5", bus_data, 32'h4600BEC8); clr();

        for (int i = 0; i < 17; i++) alu_run(vecs[i]);

        // Bus priority
        put_mdr(32'hA5A5A5A5);
        mdr_out = 1; pc_out = 1; z_low_out = 1; gpr_out = '1;
        #1 chk("prio mdr", bus_data, 32'hA5A5A5A5); clr();
        pc_out = 1; z_low_out = 1; hi_out = 1;
        #1 chk("prio pc", bus_data, 32'h00000002); clr();
        gpr_out = 16'h0034;
        #1 chk("prio gpr", bus_data, 32'h00FFFF22); clr();
        #1 chk("no source", bus_data, 32'h0);
`ifdef RISC_DATAPATH_INPORT_EN
        inport_data = 32'h13572468; tick();
        inport_out = 1; #1 chk("inport", bus_data, 32'h13572468); clr();
`else
        inport_out = 1; #1 chk("inport off", bus_data, 32'h0); clr();
`endif

        // MDR drives the bus while loading from memory in the same cycle
        mdr_out = 1; mdr_in = 1; read = 1; m_data_in = 32'h5A5A0000;
        #1 chk("mdr rmw old", bus_data, 32'hA5A5A5A5);
        tick(); clr();
        mdr_out = 1; #1 chk("mdr rmw new", bus_data, 32'h5A5A0000); clr();

        // Asynchronous reset between clock edges
        @(negedge clk);
        reset = 1;
        mdr_out = 1;    #1 chk("arst mdr", bus_data, 32'h0); clr();
        gpr_out[2] = 1; #1 chk("arst r2", bus_data, 32'h0); clr();
        lo_out = 1;     #1 chk("arst lo", bus_data, 32'h0); clr();
        pc_out = 1;     #0.5 chk("arst pc", bus_data, 32'h0); clr();
        chk("arst mar", dut.mar_q, 32'h0);
        #2 reset = 0;
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
